// File: rtl/agna_mm2s_pkg.sv
// Shared definitions for the MM2S read-command generator.
// Holds the instruction bit map, the DataMover command layout, the mode and
// FSM enums, and two small helpers (shape clipping and command packing).
package agna_mm2s_pkg;

  // Instruction bit map
  localparam int INSTR_VAR_BIT = 63;
  localparam int PTYPE_LSB     = 60;
  localparam int P_IH_LSB      = 47;   // tile_ih / layer_ih, 9b
  localparam int P_IW_LSB      = 38;   // tile_iw / layer_iw, 9b
  localparam int P_C_LSB       = 18;   // tile_c 10b, layer_c 16b
  localparam int P_IWIH_LSB    = 32;   // layer_iwih, 18b
  localparam int P_EOM_BIT     = 58;
  localparam int V_EOL_BIT     = 60;
  localparam int V_STC_LSB     = 48;   // 10b
  localparam int V_STH_LSB     = 29;   // 9b
  localparam int V_STW_LSB     = 20;   // 9b

  localparam logic [2:0] PT_TILE  = 3'b000;
  localparam logic [2:0] PT_LAYER = 3'b001;
  localparam logic [2:0] PT_IWIH  = 3'b011;
  localparam logic [2:0] PT_BADDR = 3'b111;

  // DataMover command layout
  localparam int CMD_BTT_W     = 23;
  localparam int CMD_TYPE_BIT  = 23;
  localparam int CMD_EOF_BIT   = 30;
  localparam int CMD_SADDR_LSB = 32;
  localparam int CMD_TAG_LSB   = 72;

  localparam logic [3:0] TAG_EOM  = 4'b1111;
  localparam logic [3:0] TAG_LAST = 4'b1100;
  localparam logic [3:0] TAG_NONE = 4'b0000;

  typedef enum logic [1:0] {
    MODE_ROW   = 2'b00,
    MODE_CHAN  = 2'b01,
    MODE_WHOLE = 2'b11
  } mode_e;

  typedef enum logic [2:0] {
    S_IDLE, S_C0, S_C1, S_C2, S_GEN
  } state_e;

  // Real extent of a tile along one axis. s+t > l is the overflow-free
  // form of s+t-1 > l-1 (17b sum keeps the carry).
  function automatic logic [15:0] clip(input logic [15:0] s, input logic [15:0] t,
                                       input logic [15:0] l);
    if (({1'b0, s} + {1'b0, t}) > {1'b0, l}) return l - s;
    return t;
  endfunction

  function automatic logic [79:0] pack_cmd(input logic [22:0] btt, input logic [31:0] saddr,
                                           input logic [3:0] tag);
    logic [79:0] c;
    c = '0;
    c[CMD_BTT_W-1:0]         = btt;
    c[CMD_TYPE_BIT]          = 1'b1;   // INCR burst
    c[CMD_EOF_BIT]           = 1'b1;
    c[CMD_SADDR_LSB +: 32]   = saddr;
    c[CMD_TAG_LSB +: 4]      = tag;
    return c;
  endfunction

endpackage

// File: rtl/mm2s_tile_geom.sv
// Tile geometry pipeline for the MM2S command generator.
// c0_en: latch tile start indices s_x = tile_x * st_x.
// c1_en: latch clipped real shape r_x and the empty-tile flag.
// Combinational C2 outputs: base address, command mode and btt.
// Inputs are the registered layer/tile params and variable start indices;
// they must be held stable from C0 until the tile's commands are done.
module mm2s_tile_geom
  import agna_mm2s_pkg::*;
(
  input  logic        clk,
  input  logic        c0_en,
  input  logic        c1_en,
  input  logic [8:0]  tile_ih,
  input  logic [8:0]  tile_iw,
  input  logic [9:0]  tile_c,
  input  logic [8:0]  layer_ih,
  input  logic [8:0]  layer_iw,
  input  logic [15:0] layer_c,
  input  logic [17:0] layer_iwih,
  input  logic [31:0] fin_baddr,
  input  logic [8:0]  st_h,
  input  logic [8:0]  st_w,
  input  logic [9:0]  st_c,
  output logic [31:0] base,
  output logic [1:0]  mode,
  output logic [22:0] btt,
  output logic        empty,
  output logic [15:0] r_h,
  output logic [15:0] r_c
);

  logic [15:0] s_w_q, s_w_d, s_h_q, s_h_d, s_c_q, s_c_d;
  logic [15:0] r_w_q, r_w_d, r_h_q, r_h_d, r_c_q, r_c_d;
  logic        empty_q, empty_d;
  logic        w_full;

  always_comb begin
    s_w_d   = s_w_q;
    s_h_d   = s_h_q;
    s_c_d   = s_c_q;
    r_w_d   = r_w_q;
    r_h_d   = r_h_q;
    r_c_d   = r_c_q;
    empty_d = empty_q;
    if (c0_en) begin
      s_w_d = 16'(tile_iw) * 16'(st_w);
      s_h_d = 16'(tile_ih) * 16'(st_h);
      s_c_d = 16'(tile_c) * 16'(st_c);
    end
    if (c1_en) begin
      r_w_d   = clip(s_w_q, 16'(tile_iw), 16'(layer_iw));
      r_h_d   = clip(s_h_q, 16'(tile_ih), 16'(layer_ih));
      r_c_d   = clip(s_c_q, 16'(tile_c), layer_c);
      empty_d = (s_w_q >= 16'(layer_iw)) || (s_h_q >= 16'(layer_ih)) || (s_c_q >= layer_c);
    end
  end

  always_ff @(posedge clk) begin
    s_w_q   <= s_w_d;
    s_h_q   <= s_h_d;
    s_c_q   <= s_c_d;
    r_w_q   <= r_w_d;
    r_h_q   <= r_h_d;
    r_c_q   <= r_c_d;
    empty_q <= empty_d;
  end

  // A tile spanning full rows makes each channel plane contiguous; spanning
  // full planes too makes the whole tile one contiguous burst.
  always_comb begin
    base   = fin_baddr + 32'(s_w_q) + 32'(s_h_q) * 32'(layer_iw)
           + 32'(s_c_q) * 32'(layer_iwih);
    w_full = (s_w_q == '0) && (r_w_q == 16'(layer_iw));
    if (w_full && (s_h_q == '0) && (r_h_q == 16'(layer_ih))) begin
      mode = MODE_WHOLE;
      btt  = 23'(32'(layer_iwih) * 32'(r_c_q));
    end else if (w_full) begin
      mode = MODE_CHAN;
      btt  = 23'(32'(layer_iw) * 32'(r_h_q));
    end else begin
      mode = MODE_ROW;
      btt  = 23'(r_w_q);
    end
  end

  assign empty = empty_q;
  assign r_h   = r_h_q;
  assign r_c   = r_c_q;

endmodule

// File: rtl/mm2s_cmd_gen.sv
// MM2S read-command generator: decodes param/variable sub-instructions and
// emits DataMover MM2S commands fetching one clipped fin tile from DDR.
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   s_axis_mm2s_instr_*        sub-instruction stream (tready low while busy)
//   m_axis_mm2s_cmd_*          DataMover command stream
module mm2s_cmd_gen
  import agna_mm2s_pkg::*;
#(
  parameter int CORE_INSTR_WIDTH = 64,
  parameter int CORE_CMD_WIDTH   = 80
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [CORE_INSTR_WIDTH-1:0] s_axis_mm2s_instr_tdata,
  input  logic                        s_axis_mm2s_instr_tvalid,
  output logic                        s_axis_mm2s_instr_tready,
  output logic [CORE_CMD_WIDTH-1:0]   m_axis_mm2s_cmd_tdata,
  output logic                        m_axis_mm2s_cmd_tvalid,
  input  logic                        m_axis_mm2s_cmd_tready
);

  state_e      state_q, state_d;
  logic [8:0]  tile_ih_q, tile_ih_d, tile_iw_q, tile_iw_d;
  logic [9:0]  tile_c_q, tile_c_d;
  logic [8:0]  layer_ih_q, layer_ih_d, layer_iw_q, layer_iw_d;
  logic [15:0] layer_c_q, layer_c_d;
  logic [17:0] layer_iwih_q, layer_iwih_d;
  logic [31:0] fin_baddr_q, fin_baddr_d;
  logic        eom_q, eom_d, eol_q, eol_d;
  logic [8:0]  st_h_q, st_h_d, st_w_q, st_w_d;
  logic [9:0]  st_c_q, st_c_d;
  logic [31:0] addr_q, addr_d, chan_base_q, chan_base_d;
  logic [15:0] c_idx_q, c_idx_d, h_idx_q, h_idx_d;
  mode_e       mode_q, mode_d;
  logic [22:0] btt_q, btt_d;

  logic [31:0] g_base;
  logic [1:0]  g_mode;
  logic [22:0] g_btt;
  logic        g_empty;
  logic [15:0] g_r_h, g_r_c;
  logic        instr_hs, last_cmd;
  logic [3:0]  tag;
  logic        unused_instr_bit;

  wire [63:0] instr = s_axis_mm2s_instr_tdata;
  assign unused_instr_bit = instr[59];

  assign s_axis_mm2s_instr_tready = (state_q == S_IDLE);
  assign instr_hs = s_axis_mm2s_instr_tvalid && s_axis_mm2s_instr_tready;

  mm2s_tile_geom u_geom (
    .clk        (clk),
    .c0_en      (state_q == S_C0),
    .c1_en      (state_q == S_C1),
    .tile_ih    (tile_ih_q),
    .tile_iw    (tile_iw_q),
    .tile_c     (tile_c_q),
    .layer_ih   (layer_ih_q),
    .layer_iw   (layer_iw_q),
    .layer_c    (layer_c_q),
    .layer_iwih (layer_iwih_q),
    .fin_baddr  (fin_baddr_q),
    .st_h       (st_h_q),
    .st_w       (st_w_q),
    .st_c       (st_c_q),
    .base       (g_base),
    .mode       (g_mode),
    .btt        (g_btt),
    .empty      (g_empty),
    .r_h        (g_r_h),
    .r_c        (g_r_c)
  );

  // Instruction decode
  always_comb begin
    tile_ih_d    = tile_ih_q;
    tile_iw_d    = tile_iw_q;
    tile_c_d     = tile_c_q;
    layer_ih_d   = layer_ih_q;
    layer_iw_d   = layer_iw_q;
    layer_c_d    = layer_c_q;
    layer_iwih_d = layer_iwih_q;
    fin_baddr_d  = fin_baddr_q;
    eom_d        = eom_q;
    eol_d        = eol_q;
    st_h_d       = st_h_q;
    st_w_d       = st_w_q;
    st_c_d       = st_c_q;
    if (instr_hs && instr[INSTR_VAR_BIT]) begin
      eol_d  = instr[V_EOL_BIT];
      st_c_d = instr[V_STC_LSB +: 10];
      st_h_d = instr[V_STH_LSB +: 9];
      st_w_d = instr[V_STW_LSB +: 9];
    end else if (instr_hs) begin
      case (instr[PTYPE_LSB +: 3])
        PT_TILE: begin
          tile_ih_d = instr[P_IH_LSB +: 9];
          tile_iw_d = instr[P_IW_LSB +: 9];
          tile_c_d  = instr[P_C_LSB +: 10];
        end
        PT_LAYER: begin
          layer_ih_d = instr[P_IH_LSB +: 9];
          layer_iw_d = instr[P_IW_LSB +: 9];
          layer_c_d  = instr[P_C_LSB +: 16];
        end
        PT_IWIH:  layer_iwih_d = instr[P_IWIH_LSB +: 18];
        PT_BADDR: begin
          eom_d       = instr[P_EOM_BIT];
          fin_baddr_d = instr[31:0];
        end
        default: ;
      endcase
    end
  end

  assign last_cmd = (mode_q == MODE_WHOLE) ||
                    ((c_idx_q == g_r_c - 16'd1) &&
                     ((mode_q == MODE_CHAN) || (h_idx_q == g_r_h - 16'd1)));

  // FSM and address walk
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    chan_base_d = chan_base_q;
    c_idx_d     = c_idx_q;
    h_idx_d     = h_idx_q;
    mode_d      = mode_q;
    btt_d       = btt_q;
    case (state_q)
      S_IDLE: if (instr_hs && instr[INSTR_VAR_BIT]) state_d = S_C0;
      S_C0:   state_d = S_C1;
      S_C1:   state_d = S_C2;
      S_C2: begin
        if (g_empty) begin
          state_d = S_IDLE;
        end else begin
          state_d     = S_GEN;
          addr_d      = g_base;
          chan_base_d = g_base;
          c_idx_d     = '0;
          h_idx_d     = '0;
          mode_d      = mode_e'(g_mode);
          btt_d       = g_btt;
        end
      end
      S_GEN: begin
        if (m_axis_mm2s_cmd_tready) begin
          if (last_cmd) begin
            state_d = S_IDLE;
          end else if (mode_q == MODE_CHAN) begin
            c_idx_d = c_idx_q + 16'd1;
            addr_d  = addr_q + 32'(layer_iwih_q);
          end else if (h_idx_q == g_r_h - 16'd1) begin
            // Channel wrap: restart from the next plane, not from the row walk.
            h_idx_d     = '0;
            c_idx_d     = c_idx_q + 16'd1;
            chan_base_d = chan_base_q + 32'(layer_iwih_q);
            addr_d      = chan_base_q + 32'(layer_iwih_q);
          end else begin
            h_idx_d = h_idx_q + 16'd1;
            addr_d  = addr_q + 32'(layer_iw_q);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
    tile_ih_q    <= tile_ih_d;
    tile_iw_q    <= tile_iw_d;
    tile_c_q     <= tile_c_d;
    layer_ih_q   <= layer_ih_d;
    layer_iw_q   <= layer_iw_d;
    layer_c_q    <= layer_c_d;
    layer_iwih_q <= layer_iwih_d;
    fin_baddr_q  <= fin_baddr_d;
    eom_q        <= eom_d;
    eol_q        <= eol_d;
    st_h_q       <= st_h_d;
    st_w_q       <= st_w_d;
    st_c_q       <= st_c_d;
    addr_q       <= addr_d;
    chan_base_q  <= chan_base_d;
    c_idx_q      <= c_idx_d;
    h_idx_q      <= h_idx_d;
    mode_q       <= mode_d;
    btt_q        <= btt_d;
  end

  assign tag = !last_cmd ? TAG_NONE : (eol_q && eom_q) ? TAG_EOM : TAG_LAST;
  assign m_axis_mm2s_cmd_tvalid = (state_q == S_GEN);
  assign m_axis_mm2s_cmd_tdata  = pack_cmd(btt_q, addr_q, tag);

endmodule

// File: tb/tb_mm2s_cmd_gen.sv
module tb_mm2s_cmd_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] instr_tdata;
  logic        instr_tvalid, instr_tready;
  logic [79:0] cmd_tdata;
  logic        cmd_tvalid, cmd_tready;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mm2s_cmd_gen dut (
    .clk                      (clk),
    .rst_n                    (rst_n),
    .s_axis_mm2s_instr_tdata  (instr_tdata),
    .s_axis_mm2s_instr_tvalid (instr_tvalid),
    .s_axis_mm2s_instr_tready (instr_tready),
    .m_axis_mm2s_cmd_tdata    (cmd_tdata),
    .m_axis_mm2s_cmd_tvalid   (cmd_tvalid),
    .m_axis_mm2s_cmd_tready   (cmd_tready)
  );

  typedef struct {
    logic [8:0]       l_ih, l_iw;
    logic [15:0]      l_c;
    logic [17:0]      iwih;
    logic [8:0]       t_ih, t_iw;
    logic [9:0]       t_c;
    logic [31:0]      baddr;
    logic             eom;
    logic [8:0]       st_w, st_h;
    logic [9:0]       st_c;
    logic             eol;
    logic [3:0]       rdy;
    int               n;
    logic [22:0]      btt;
    logic [3:0][31:0] a;
  } vec_t;

  vec_t vecs[8];

  function automatic vec_t mkv(int l_ih, int l_iw, int l_c, int iwih, int t_ih, int t_iw,
                               int t_c, logic [31:0] baddr, int eom, int st_w, int st_h,
                               int st_c, int eol, logic [3:0] rdy, int n, int btt,
                               logic [31:0] a0, logic [31:0] a1, logic [31:0] a2,
                               logic [31:0] a3);
    vec_t v;
    v.l_ih = 9'(l_ih);   v.l_iw = 9'(l_iw);   v.l_c = 16'(l_c);  v.iwih = 18'(iwih);
    v.t_ih = 9'(t_ih);   v.t_iw = 9'(t_iw);   v.t_c = 10'(t_c);  v.baddr = baddr;
    v.eom  = 1'(eom);    v.st_w = 9'(st_w);   v.st_h = 9'(st_h); v.st_c = 10'(st_c);
    v.eol  = 1'(eol);    v.rdy = rdy;         v.n = n;           v.btt = 23'(btt);
    v.a[0] = a0; v.a[1] = a1; v.a[2] = a2; v.a[3] = a3;
    return v;
  endfunction

  // Expected command built from the field layout of the DataMover command.
  function automatic logic [79:0] exp_cmd(logic [22:0] btt, logic [31:0] addr, logic [3:0] tag);
    logic [79:0] c;
    c = '0;
    c[22:0]  = btt;
    c[23]    = 1'b1;
    c[30]    = 1'b1;
    c[63:32] = addr;
    c[75:72] = tag;
    return c;
  endfunction

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk80(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic send(input logic [63:0] d);
    int n;
    n = 0;
    @(negedge clk);
    instr_tdata  = d;
    instr_tvalid = 1'b1;
    while (!instr_tready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk1("instr_tready", instr_tready, 1'b1);
    @(posedge clk);
    #1 instr_tvalid = 1'b0;
  endtask

  task automatic load(input vec_t v, input bit junk);
    logic [63:0] d;
    d = '0; d[55:47] = v.t_ih; d[46:38] = v.t_iw; d[27:18] = v.t_c;
    send(d);
    d = '0; d[62:60] = 3'b001; d[55:47] = v.l_ih; d[46:38] = v.l_iw; d[33:18] = v.l_c;
    send(d);
    d = '0; d[62:60] = 3'b011; d[49:32] = v.iwih;
    send(d);
    d = '0; d[62:60] = 3'b111; d[58] = v.eom; d[31:0] = v.baddr;
    send(d);
    if (junk) begin
      // Undefined param codes carrying all-ones payloads must be dropped.
      send({1'b0, 3'b101, 60'hFFF_FFFF_FFFF_FFFF});
      send({1'b0, 3'b110, 60'hFFF_FFFF_FFFF_FFFF});
      send({1'b0, 3'b010, 60'hFFF_FFFF_FFFF_FFFF});
      send({1'b0, 3'b100, 60'hFFF_FFFF_FFFF_FFFF});
    end
    d = '0; d[63] = 1'b1; d[60] = v.eol; d[57:48] = v.st_c; d[37:29] = v.st_h;
    d[28:20] = v.st_w;
    send(d);
    // Variable handshake done; the next negedge lies in cycle T+1.
  endtask

  task automatic run_vec(input vec_t v, input bit junk);
    int got, cyc;
    logic [3:0] tg;
    load(v, junk);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      chk1("lat_tvalid", cmd_tvalid, 1'b0);
    end
    @(negedge clk);  // cycle T+4
    if (v.n == 0) begin
      chk1("empty_tready", instr_tready, 1'b1);
      chk1("empty_tvalid", cmd_tvalid, 1'b0);
      repeat (2) begin
        @(negedge clk);
        chk1("empty_tvalid", cmd_tvalid, 1'b0);
      end
    end else begin
      got = 0;
      cyc = 0;
      while (got < v.n && cyc < 40) begin
        cmd_tready = v.rdy[cyc % 4];
        chk1("cmd_tvalid", cmd_tvalid, 1'b1);
        tg = (got != v.n - 1) ? 4'b0000 : (v.eol && v.eom) ? 4'b1111 : 4'b1100;
        chk80("cmd_tdata", cmd_tdata, exp_cmd(v.btt, v.a[got], tg));
        if (cmd_tvalid && cmd_tready) got++;
        cyc++;
        @(negedge clk);
      end
      if (got < v.n) begin
        checks++;
        errors++;
        $display("FAIL cmd_count: got %0d commands expected %0d", got, v.n);
      end
      cmd_tready = 1'b0;
      chk1("done_tvalid", cmd_tvalid, 1'b0);
      chk1("done_tready", instr_tready, 1'b1);
    end
  endtask

  initial begin
    vecs[0] = mkv(8, 8, 4, 64, 8, 8, 4, 32'h1000, 1, 0, 0, 0, 1, 4'b1111, 1, 256,
                  32'h1000, 0, 0, 0);
    vecs[1] = mkv(8, 8, 16, 64, 4, 8, 4, 32'h0, 0, 0, 1, 2, 0, 4'b1111, 4, 32,
                  544, 608, 672, 736);
    vecs[2] = mkv(10, 10, 4, 100, 4, 4, 2, 32'h0, 1, 2, 2, 0, 1, 4'b1111, 4, 2,
                  88, 98, 188, 198);
    vecs[3] = mkv(10, 10, 4, 100, 4, 4, 2, 32'h0, 1, 2, 2, 0, 0, 4'b1001, 4, 2,
                  88, 98, 188, 198);
    vecs[4] = mkv(10, 10, 4, 100, 4, 4, 2, 32'h0, 1, 3, 0, 0, 1, 4'b1111, 0, 0,
                  0, 0, 0, 0);
    vecs[5] = mkv(8, 8, 4, 64, 8, 8, 4, 32'h200, 0, 0, 0, 0, 1, 4'b1111, 1, 256,
                  32'h200, 0, 0, 0);
    vecs[6] = mkv(8, 8, 16, 64, 4, 8, 4, 32'hFFFF_FF00, 1, 0, 1, 2, 1, 4'b1111, 4, 32,
                  32'h120, 32'h160, 32'h1A0, 32'h1E0);
    vecs[7] = mkv(10, 10, 3, 100, 4, 4, 2, 32'h0, 0, 0, 0, 1, 0, 4'b0111, 4, 4,
                  200, 210, 220, 230);

    rst_n        = 1'b0;
    instr_tdata  = '0;
    instr_tvalid = 1'b0;
    cmd_tready   = 1'b0;
    repeat (3) @(negedge clk);
    chk1("rst_tready", instr_tready, 1'b1);
    chk1("rst_tvalid", cmd_tvalid, 1'b0);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) run_vec(vecs[i], i == 1);

    // Reset during GEN after the first of four row commands.
    load(vecs[2], 1'b0);
    repeat (4) @(negedge clk);
    cmd_tready = 1'b1;
    chk80("mid_cmd0", cmd_tdata, exp_cmd(23'd2, 32'd88, 4'b0000));
    @(negedge clk);
    chk80("mid_cmd1", cmd_tdata, exp_cmd(23'd2, 32'd98, 4'b0000));
    rst_n      = 1'b0;
    cmd_tready = 1'b0;
    @(negedge clk);
    chk1("abort_tvalid", cmd_tvalid, 1'b0);
    chk1("abort_tready", instr_tready, 1'b1);
    rst_n = 1'b1;
    run_vec(vecs[2], 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d checks %0d errors", checks, errors);
    $fatal(1);
  end

endmodule
